// File: rtl/dual_port_ram_be.sv
// Single-clock true dual-port RAM with byte enables, post-reset clear and write-collision
// arbitration (port A wins shared lanes). Define DUAL_PORT_RAM_STATS_EN to add collision_count.
module dual_port_ram_be #(
  parameter int size     = 256,
  parameter int width    = 32,
  parameter int depth    = 8,
  parameter int lane     = 8,
  parameter int rdw_mode = 0,
  parameter int out_reg  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  ready,
  input  logic                  en_a,
  input  logic [depth-1:0]      address_a,
  input  logic [width-1:0]      data_a,
  input  logic                  data_a_valid,
  input  logic [width/lane-1:0] be_a,
  output logic [width-1:0]      q_a,
  output logic                  q_a_valid,
  input  logic                  en_b,
  input  logic [depth-1:0]      address_b,
  input  logic [width-1:0]      data_b,
  input  logic                  data_b_valid,
  input  logic [width/lane-1:0] be_b,
  output logic [width-1:0]      q_b,
  output logic                  q_b_valid,
  output logic                  collision
`ifdef DUAL_PORT_RAM_STATS_EN
  ,
  output logic [15:0]           collision_count
`endif
);

  localparam int lanes = width / lane;
  localparam int aw = (size > 32'sd1) ? $clog2(size) : 32'sd1;
  localparam logic [depth:0] size_l = (depth+1)'(size);
  localparam logic [aw-1:0] last_addr = aw'(size - 32'sd1);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           state_r;
  logic             ready_r;
  logic [aw-1:0]    clr_cnt_r;
  logic [width-1:0] mem_r [0:size-1];
  logic [width-1:0] q1_a_r, q1_b_r;
  logic             v1_a_r, v1_b_r;
  logic             collision_r;

  logic             run_s, acc_a_s, acc_b_s, in_a_s, in_b_s, wr_a_s, wr_b_s, coll_s;
  logic [aw-1:0]    idx_a_s, idx_b_s;
  logic [width-1:0] old_a_s, old_b_s, merged_a_s, merged_b_s, nq_a_s, nq_b_s;

  // Lane merge: mask_a lanes take data_a, else mask_b lanes take data_b, else keep old.
  function automatic logic [width-1:0] merge_word(input logic [width-1:0] old_w,
      input logic [width-1:0] da, input logic [lanes-1:0] mask_a,
      input logic [width-1:0] db, input logic [lanes-1:0] mask_b);
    logic [width-1:0] r;
    r = old_w;
    for (int i = 0; i < lanes; i++) begin
      if (mask_a[i]) r[i*lane +: lane] = da[i*lane +: lane];
      else if (mask_b[i]) r[i*lane +: lane] = db[i*lane +: lane];
      else r[i*lane +: lane] = old_w[i*lane +: lane];
    end
    return r;
  endfunction

  function automatic logic [width-1:0] read_word(input logic in_rng, input logic wr,
      input logic [width-1:0] old_w, input logic [width-1:0] merged_w,
      input logic [width-1:0] q_prev);
    logic [width-1:0] r;
    if (!in_rng) r = '0;
    else if (!wr) r = old_w;
    else begin
      case (rdw_mode)
        32'sd1:  r = old_w;
        32'sd2:  r = q_prev;
        default: r = merged_w;
      endcase
    end
    return r;
  endfunction

  // Access decode, old-word fetch and arbitrated merge for both ports.
  always_comb begin
    run_s    = (state_r == ST_RUN) && !reset;
    acc_a_s  = run_s && en_a;
    acc_b_s  = run_s && en_b;
    in_a_s   = {1'b0, address_a} < size_l;
    in_b_s   = {1'b0, address_b} < size_l;
    idx_a_s  = address_a[aw-1:0];
    idx_b_s  = address_b[aw-1:0];
    wr_a_s   = acc_a_s && data_a_valid && (|be_a) && in_a_s;
    wr_b_s   = acc_b_s && data_b_valid && (|be_b) && in_b_s;
    coll_s   = wr_a_s && wr_b_s && (idx_a_s == idx_b_s);
    old_a_s  = in_a_s ? mem_r[idx_a_s] : '0;
    old_b_s  = in_b_s ? mem_r[idx_b_s] : '0;
    // On a collision both merges see both masks, so the two stored words agree.
    merged_a_s = merge_word(old_a_s, data_a, wr_a_s ? be_a : '0, data_b, coll_s ? be_b : '0);
    merged_b_s = merge_word(old_b_s, data_a, coll_s ? be_a : '0, data_b, wr_b_s ? be_b : '0);
    nq_a_s   = read_word(in_a_s, wr_a_s, old_a_s, merged_a_s, q1_a_r);
    nq_b_s   = read_word(in_b_s, wr_b_s, old_b_s, merged_b_s, q1_b_r);
  end

  // Clear sequencer, first read stage and collision pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_CLEAR;
      ready_r     <= 1'b0;
      clr_cnt_r   <= '0;
      q1_a_r      <= '0;
      q1_b_r      <= '0;
      v1_a_r      <= 1'b0;
      v1_b_r      <= 1'b0;
      collision_r <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (clr_cnt_r == last_addr) begin
            state_r <= ST_RUN;
            ready_r <= 1'b1;
          end else begin
            clr_cnt_r <= clr_cnt_r + aw'(1);
          end
        end
        ST_RUN: ready_r <= 1'b1;
        default: begin
          state_r   <= ST_CLEAR;
          ready_r   <= 1'b0;
          clr_cnt_r <= '0;
        end
      endcase
      v1_a_r      <= acc_a_s;
      v1_b_r      <= acc_b_s;
      collision_r <= coll_s;
      if (acc_a_s) q1_a_r <= nq_a_s;
      if (acc_b_s) q1_b_r <= nq_b_s;
    end
  end

  // Storage array: zero-fill during clear, arbitrated port writes in run.
  always_ff @(posedge clock) begin
    if (!reset && state_r == ST_CLEAR) begin
      mem_r[clr_cnt_r] <= '0;
    end else begin
      if (wr_a_s) mem_r[idx_a_s] <= merged_a_s;
      if (wr_b_s) mem_r[idx_b_s] <= merged_b_s;
    end
  end

  generate
    if (out_reg != 0) begin : g_out_reg
      logic [width-1:0] q2_a_r, q2_b_r;
      logic             v2_a_r, v2_b_r;
      // Second stage advances only on first-stage valid, so back-to-back reads stream.
      always_ff @(posedge clock) begin
        if (reset) begin
          q2_a_r <= '0;
          q2_b_r <= '0;
          v2_a_r <= 1'b0;
          v2_b_r <= 1'b0;
        end else begin
          v2_a_r <= v1_a_r;
          v2_b_r <= v1_b_r;
          if (v1_a_r) q2_a_r <= q1_a_r;
          if (v1_b_r) q2_b_r <= q1_b_r;
        end
      end
      assign q_a = q2_a_r;
      assign q_b = q2_b_r;
      assign q_a_valid = v2_a_r;
      assign q_b_valid = v2_b_r;
    end else begin : g_no_out_reg
      assign q_a = q1_a_r;
      assign q_b = q1_b_r;
      assign q_a_valid = v1_a_r;
      assign q_b_valid = v1_b_r;
    end
  endgenerate

  assign ready     = ready_r;
  assign collision = collision_r;

`ifdef DUAL_PORT_RAM_STATS_EN
  logic [15:0] coll_cnt_r;
  // Saturating collision counter; survives the clear sequence, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) coll_cnt_r <= 16'h0000;
    else if (coll_s && coll_cnt_r != 16'hFFFF) coll_cnt_r <= coll_cnt_r + 16'h0001;
  end
  assign collision_count = coll_cnt_r;
`endif

endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
- Single-clock true dual-port inferred RAM: per-lane byte enables, selectable read-during-write mode, optional output register, read-valid tracking.
- Adds a post-reset clear sequencer and write-collision arbitration.
- Shared buffer primitive for FIFOs, line buffers and scratchpads in std/mem.

Parameters:
- size, 256: number of words.
- width, 32: word width in bits; must be a multiple of lane.
- depth, 8: address width in bits; 2**depth >= size.
- lane, 8: bits per byte-enable lane; lanes = width/lane.
- rdw_mode, 0: same-port read-during-write. 0 = write-first (q = new merged word), 1 = read-first (q = old word), 2 = no-change (q holds).
- out_reg, 0: 1 adds an output pipeline register. Read latency = 1 + out_reg.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- ready  out  1  high when the clear sequence has finished and ports accept accesses.
- en_a  in  1  port A access enable.
- address_a  in  depth  port A address.
- data_a  in  width  port A write data.
- data_a_valid  in  1  port A write (qualified by en_a).
- be_a  in  lanes  port A lane write enables.
- q_a  out  width  port A read data.
- q_a_valid  out  1  q_a carries the result of an access.
- en_b, address_b, data_b, data_b_valid, be_b, q_b, q_b_valid: same as port A, for port B.
- collision  out  1  one-cycle pulse: both ports wrote the same address.

Behaviour:
- Reset, taken at the clock edge while reset=1: ready=0, q_a=q_b=0, q_a_valid=q_b_valid=0, collision=0. Clear counter loads 0 and the FSM enters CLEAR.
- FSM CLEAR:
  - Writes all-zero words to address counter, one per cycle, counter 0..size-1.
  - In the cycle after writing size-1: go to RUN and ready=1.
  - Clear takes exactly size cycles after reset deasserts.
  - While ready=0, all port inputs are ignored: no writes, q_*_valid stay 0, q_* hold 0.
- Reset asserted mid-CLEAR or in RUN restarts CLEAR from address 0.
- RUN:
  - An access happens on a port when en_x=1.
  - Write when data_x_valid=1: only lanes with be_x[i]=1 are updated. data_x_valid=1 with be_x=0 is a read with no memory change.
  - q_x_valid goes high exactly 1+out_reg cycles after the access and is otherwise 0.
  - When en_x=0: q_x holds its last value.
- Same-port read-during-write: q_x follows rdw_mode.
  - Write-first returns the merged word (old lanes plus new lanes).
  - No-change: q_x_valid still pulses; q_x keeps its previous value.
- Cross-port, same cycle, same address, one port writing and the other reading: the reader gets the OLD word.
- Both ports write the same address in the same cycle:
  - Port A wins on every lane it enables.
  - Port B lanes not enabled by A are written from B.
  - collision=1 in the following cycle, for one cycle.
  - Each port's q follows its own rdw_mode, using the final stored word for write-first.
- Addresses >= size: writes dropped, read data = 0, valid still pulses.
- out_reg=1: the second stage is clock-enabled by the first-stage valid; no bubbles for back-to-back accesses.
- Throughput: one access per port per cycle.

Optional Feature:
- Macro DUAL_PORT_RAM_STATS_EN.
- When defined:
  - Adds output collision_count, 16 bits.
  - Increments on each collision pulse and saturates at 16'hFFFF.
  - Cleared by reset only, not by the clear sequence.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- size=16, out_reg=0: pulse reset one cycle → ready low for exactly 16 cycles then high. Read all 16 addresses on port B → every q_b=0, each q_b_valid one cycle after en_b.
- Port A writes 32'hDEADBEEF to address 3 with be_a=4'b1111, then 32'h00000011 with be_a=4'b0001 → port B read of address 3 returns 32'hDEADBE11.
- rdw_mode=0/1/2, memory word 32'hAAAAAAAA, port A writes 32'h55555555 full lanes with en_a=1 → q_a = 32'h55555555 / 32'hAAAAAAAA / previous q_a respectively.
- Same cycle:
  - A writes 32'h11111111 with be_a=4'b0011.
  - B writes 32'h22222222 with be_b=4'b1111, same address.
  - → stored word 32'h22221111; collision=1 for one cycle.
  - With DUAL_PORT_RAM_STATS_EN defined, collision_count=1.
- out_reg=1, port B reads addresses 0..7 back-to-back → q_b_valid high 8 consecutive cycles starting 2 cycles after the first en_b; data in order.
- Assert reset at clear counter=5, then release → ready stays low 16 more cycles. A write attempted during clear is not stored: a read after ready returns 0.
